jump_redirect_ctrl: RTL and testbench

//   Sequences the front end when the EX-stage jump unit resolves a taken branch/jump.

---
 rtl/jump_redirect_ctrl.sv | 149 ++++++++++++++
 tb/tb_jump_redirect_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_redirect_ctrl.sv
// Front-end redirect sequencer: boot fetch, taken-jump redirect handshake,
// wrong-path flush window and saturating redirect counter.
module jump_redirect_ctrl #(
  parameter int unsigned       BUS_W     = 32,
  parameter logic [BUS_W-1:0]  RESET_PC  = '0,
  parameter int unsigned       FLUSH_CYC = 2,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             exValid_in,
  input  logic             jumpEn_in,
  input  logic [BUS_W-1:0] jumpAddr_in,
  input  logic             fetchReady_in,
  output logic             redirectValid_out,
  output logic [BUS_W-1:0] redirectAddr_out,
  output logic             flush_out,
  output logic             stall_out,
  output logic             misalign_out,
  output logic [CNT_W-1:0] redirectCnt_out
);

  typedef enum logic [1:0] {
    BOOT,
    IDLE,
    REDIR,
    FLUSH
  } state_e;

  localparam logic [3:0] FC_M1 =
    (FLUSH_CYC > 0) ? 4'(FLUSH_CYC - 1) : 4'd0;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic             flush_q, flush_d;
  logic             stall_q, stall_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             boot_q, boot_d;

  logic taken;
  logic aligned;
  logic hs;

  assign taken   = exValid_in & jumpEn_in;
  assign aligned = (jumpAddr_in[1:0] == 2'b00);
  assign hs      = valid_q & fetchReady_in;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    flush_d = flush_q;
    stall_d = stall_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    boot_d  = boot_q;
    unique case (state_q)
      BOOT: begin
        state_d = REDIR;
        valid_d = 1'b1;
        addr_d  = RESET_PC;
        flush_d = 1'b1;
        stall_d = 1'b1;
        boot_d  = 1'b1;
      end
      IDLE: begin
        valid_d = 1'b0;
        flush_d = 1'b0;
        stall_d = 1'b0;
        if (taken) begin
          if (aligned) begin
            state_d = REDIR;
            valid_d = 1'b1;
            addr_d  = jumpAddr_in;
            flush_d = 1'b1;
            stall_d = 1'b1;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      REDIR: begin
        if (hs) begin
          valid_d = 1'b0;
          stall_d = 1'b0;
          boot_d  = 1'b0;
          // boot redirect is not counted
          if (!boot_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (FLUSH_CYC > 0) begin
            state_d = FLUSH;
            fcnt_d  = FC_M1;
            flush_d = 1'b1;
          end else begin
            state_d = IDLE;
            flush_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (fcnt_q == 4'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= BOOT;
      valid_q <= 1'b0;
      addr_q  <= RESET_PC;
      flush_q <= 1'b1;
      stall_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
      fcnt_q  <= 4'd0;
      boot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      boot_q  <= boot_d;
    end
  end

  assign redirectValid_out = valid_q;
  assign redirectAddr_out  = addr_q;
  assign flush_out         = flush_q;
  assign stall_out         = stall_q;
  assign misalign_out      = mis_q;
  assign redirectCnt_out   = cnt_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Bench for jump_redirect_ctrl: default build and a FLUSH_CYC=0 / CNT_W=2
// build share stimulus and are checked against a transaction-level model.
module tb_jump_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] addr = '0;
  logic        rdy = 1'b0;

  logic        v0, f0, s0, m0;
  logic [31:0] a0;
  logic [15:0] c0;
  logic        v1, f1, s1, m1;
  logic [31:0] a1;
  logic [1:0]  c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jump_redirect_ctrl #(
    .BUS_W(32), .RESET_PC(32'h0), .FLUSH_CYC(2), .CNT_W(16)
  ) u0 (
    .clk_in(clk), .rst_in(rst), .exValid_in(ex), .jumpEn_in(jmp),
    .jumpAddr_in(addr), .fetchReady_in(rdy),
    .redirectValid_out(v0), .redirectAddr_out(a0), .flush_out(f0),
    .stall_out(s0), .misalign_out(m0), .redirectCnt_out(c0)
  );

  jump_redirect_ctrl #(
    .BUS_W(32), .RESET_PC(32'h0), .FLUSH_CYC(0), .CNT_W(2)
  ) u1 (
    .clk_in(clk), .rst_in(rst), .exValid_in(ex), .jumpEn_in(jmp),
    .jumpAddr_in(addr), .fetchReady_in(rdy),
    .redirectValid_out(v1), .redirectAddr_out(a1), .flush_out(f1),
    .stall_out(s1), .misalign_out(m1), .redirectCnt_out(c1)
  );

  // Transaction-level view: pending redirect, flush cycles left, count.
  typedef struct {
    bit          boot;
    bit          pend;
    bit          isboot;
    int          rem;
    int          cnt;
    bit          v;
    logic [31:0] a;
    bit          f;
    bit          s;
    bit          mis;
  } mdl_t;

  mdl_t md[2];
  int   fc[2]   = '{2, 0};
  int   cmax[2] = '{65535, 3};

  function automatic void mreset(int i);
    md[i].boot   = 1'b1;
    md[i].pend   = 1'b0;
    md[i].isboot = 1'b0;
    md[i].rem    = 0;
    md[i].cnt    = 0;
    md[i].v      = 1'b0;
    md[i].a      = 32'h0;
    md[i].f      = 1'b1;
    md[i].s      = 1'b0;
    md[i].mis    = 1'b0;
  endfunction

  function automatic void mstep(int i);
    md[i].mis = 1'b0;
    if (md[i].boot) begin
      md[i].boot = 1'b0; md[i].pend = 1'b1; md[i].isboot = 1'b1;
      md[i].v = 1'b1; md[i].a = 32'h0; md[i].f = 1'b1; md[i].s = 1'b1;
    end else if (md[i].pend) begin
      if (rdy) begin
        md[i].pend = 1'b0; md[i].v = 1'b0; md[i].s = 1'b0;
        if (!md[i].isboot && md[i].cnt < cmax[i]) md[i].cnt++;
        md[i].isboot = 1'b0;
        md[i].rem = fc[i];
        md[i].f = (md[i].rem > 0);
      end
    end else if (md[i].rem > 0) begin
      md[i].rem--;
      md[i].f = (md[i].rem > 0);
    end else begin
      md[i].f = 1'b0;
      if (ex && jmp) begin
        if (addr[1:0] == 2'b00) begin
          md[i].pend = 1'b1; md[i].v = 1'b1; md[i].a = addr;
          md[i].f = 1'b1; md[i].s = 1'b1;
        end else begin
          md[i].mis = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mreset(0); mreset(1);
    end else begin
      mstep(0); mstep(1);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    mreset(0); mreset(1);
    forever begin
      @(posedge clk);
      #1;
      chk("v0", 32'(v0), 32'(md[0].v));
      chk("a0", a0, md[0].a);
      chk("f0", 32'(f0), 32'(md[0].f));
      chk("s0", 32'(s0), 32'(md[0].s));
      chk("m0", 32'(m0), 32'(md[0].mis));
      chk("c0", 32'(c0), 32'(md[0].cnt));
      chk("v1", 32'(v1), 32'(md[1].v));
      chk("a1", a1, md[1].a);
      chk("f1", 32'(f1), 32'(md[1].f));
      chk("s1", 32'(s1), 32'(md[1].s));
      chk("m1", 32'(m1), 32'(md[1].mis));
      chk("c1", 32'(c1), 32'(md[1].cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic take(logic [31:0] t);
    ex = 1'b1; jmp = 1'b1; addr = t;
  endtask

  initial begin
    rdy = 1'b1;
    tick(); tick();
    chk("rst_v", 32'(v0), 32'd0);
    chk("rst_f", 32'(f0), 32'd1);
    chk("rst_s", 32'(s0), 32'd0);
    chk("rst_c", 32'(c0), 32'd0);
    rst = 1'b0;
    tick();
    chk("boot_v", 32'(v0), 32'd1);
    chk("boot_a", a0, 32'h0);
    chk("boot_f", 32'(f0), 32'd1);
    tick();
    chk("boot_hs_v", 32'(v0), 32'd0);
    chk("boot_hs_f", 32'(f0), 32'd1);
    chk("boot_cnt", 32'(c0), 32'd0);
    tick();
    chk("boot_fl2", 32'(f0), 32'd1);
    tick();
    chk("boot_fl_end", 32'(f0), 32'd0);

    rdy = 1'b0;
    take(32'h100);
    tick();
    chk("j_v", 32'(v0), 32'd1);
    chk("j_a", a0, 32'h100);
    chk("j_s", 32'(s0), 32'd1);
    take(32'h200);
    tick();
    chk("j_hold_a", a0, 32'h100);
    tick();
    chk("j_hold_v", 32'(v0), 32'd1);
    chk("j_ign_a", a0, 32'h100);
    rdy = 1'b1; ex = 1'b0;
    tick();
    chk("j_acc_v", 32'(v0), 32'd0);
    chk("j_acc_s", 32'(s0), 32'd0);
    chk("j_cnt", 32'(c0), 32'd1);
    chk("j_f1_fc0", 32'(f1), 32'd0);
    rdy = 1'b0;
    take(32'h200);
    tick();
    chk("fl_ign_a", a0, 32'h100);
    chk("fl_ign_v", 32'(v0), 32'd0);
    ex = 1'b0;
    tick();
    chk("fl_end", 32'(f0), 32'd0);

    take(32'h102);
    tick();
    chk("mis_p", 32'(m0), 32'd1);
    chk("mis_v", 32'(v0), 32'd0);
    ex = 1'b0; addr = 32'h300;
    tick();
    chk("mis_end", 32'(m0), 32'd0);
    chk("exv0_v", 32'(v0), 32'd0);

    take(32'h100);
    tick();
    ex = 1'b0;
    chk("pre_rst_v", 32'(v0), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_v", 32'(v0), 32'd0);
    chk("arst_a", a0, 32'h0);
    chk("arst_f", 32'(f0), 32'd1);
    chk("arst_c", 32'(c0), 32'd0);
    tick();
    rst = 1'b0; rdy = 1'b1;
    tick();
    chk("reboot_v", 32'(v0), 32'd1);
    chk("reboot_a", a0, 32'h0);
    tick(); tick(); tick();

    for (int k = 1; k <= 5; k++) begin
      take(32'(k) << 6);
      tick();
      ex = 1'b0;
      tick(); tick(); tick();
    end
    chk("sat_c1", 32'(c1), 32'd3);
    chk("cnt_c0", 32'(c0), 32'd5);

    for (int n = 0; n < 3000; n++) begin
      ex   = 1'($urandom_range(0, 1));
      jmp  = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      rdy  = 1'($urandom_range(0, 1));
      if (!rst && $urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
